gpr_dump: RTL

GPR_DUMP -- requirements
Module: gpr_dump

---
 rtl/gpr_dump.sv | 107 ++++++++++
 1 files changed

// File: rtl/gpr_dump.sv
// Register-file dump engine: walks an inclusive address range over a combinational
// read port and streams each word out with a valid/ready handshake and running XOR.
module gpr_dump #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] checksum,
    output logic [1:0]        fsm_state
);

    // Stream handshake: a word transfers on a rising edge where out_valid && out_ready;
    // out_data/out_addr/out_last are held stable while out_valid is high and unaccepted.

    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cur, end_addr;
    logic              start_ok;

    assign start_ok  = start && (first_addr <= last_addr);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_addr   = '0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE: if (start_ok) state_nxt = READ;
            READ: begin
                rd_addr   = cur;
                state_nxt = SEND;
            end
            SEND: begin
                rd_addr   = cur;
                out_valid = 1'b1;
                if (out_ready) state_nxt = (cur == end_addr) ? DONE : READ;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur      <= '0;
            end_addr <= '0;
            out_data <= '0;
            out_addr <= '0;
            out_last <= 1'b0;
            checksum <= '0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        cur      <= first_addr;
                        end_addr <= last_addr;
                        checksum <= '0;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                READ: begin
                    out_data <= rd_data;
                    out_addr <= cur;
                    out_last <= (cur == end_addr);
                    checksum <= checksum ^ rd_data;
                end
                SEND: begin
                    // Equality stop: cur never increments past end_addr, so no wrap.
                    if (out_ready && (cur != end_addr)) cur <= cur + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
